// File: rtl/msoc_oci_pkg.sv
// Shared constants and types for the OCI data-trace packer.
//   SYM_W    : bits per trace symbol
//   MAX_SYMS : symbols per full frame
//   BUF_W    : packed frame width (SYM_W*MAX_SYMS)
//   CNT_W    : width of the valid-symbol count
package msoc_oci_pkg;

  localparam int unsigned SYM_W    = 2;
  localparam int unsigned MAX_SYMS = 15;
  localparam int unsigned BUF_W    = 30;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned FRAME_W  = BUF_W + CNT_W;

  // End-of-test sequencing states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } state_t;

  // Frame payload handed to the output register
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } frame_t;

endpackage

// File: rtl/msoc_oci_frame_reg.sv
// One-deep valid/ready output register for packed trace frames.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_frame (only asserted while out_free_c)
//   load_frame  : frame to capture
//   ready       : consumer takes the frame when valid & ready
//   valid       : frame register holds a frame
//   frame       : held frame, stable while valid & !ready
//   out_free_c  : register can take a new frame this cycle
module msoc_oci_frame_reg
  import msoc_oci_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  frame_t load_frame,
  input  logic   ready,
  output logic   valid,
  output frame_t frame,
  output logic   out_free_c
);

  // A consumed frame frees the slot in the same cycle, allowing back-to-back frames
  assign out_free_c = !valid | ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      frame <= '0;
    end else if (load) begin
      valid <= 1'b1;
      frame <= load_frame;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/msoc_cpu_oci_dct_packer.sv
// Packs 2-bit OCI data-trace symbols LSB-first into 30-bit frames with a
// symbol count, delivered over a valid/ready handshake, and sequences the
// end of test (pulse test_ending, drain the partial frame, hold test_has_ended).
//   clk, reset      : clock, synchronous active-high reset
//   sym_valid/data  : incoming trace symbol
//   sym_ready       : symbol accepted this cycle when sym_valid & sym_ready
//   flush           : close the partial frame
//   test_end_req    : request end of test
//   dct_buffer/count: packed frame and its valid-symbol count
//   dct_valid/ready : output handshake
//   test_ending     : one-cycle pulse on an accepted end request
//   test_has_ended  : sticky once the drain has completed
module msoc_cpu_oci_dct_packer
  import msoc_oci_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  input  logic             flush,
  input  logic             test_end_req,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             dct_valid,
  input  logic             dct_ready,
  output logic             test_ending,
  output logic             test_has_ended
);

  state_t           state, state_n;
  logic [BUF_W-1:0] acc_buf, acc_buf_n, wr_buf;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_n, wr_cnt;
  logic             flush_pend, flush_pend_n;
  logic             sym_ready_n;
  logic             accept, end_accept, flush_req, close, load;
  logic             out_free;
  frame_t           load_frame, out_frame;

  // Accumulator update, frame close decision and end-of-test sequencing
  always_comb begin
    wr_buf       = acc_buf;
    wr_cnt       = acc_cnt;
    acc_buf_n    = acc_buf;
    acc_cnt_n    = acc_cnt;
    flush_pend_n = flush_pend;
    state_n      = state;
    load_frame   = '0;

    // sym_ready already folds in state==RUN and a non-full accumulator
    accept     = sym_valid & sym_ready;
    end_accept = (state == RUN) & test_end_req;

    if (accept) begin
      wr_buf[SYM_W*32'(acc_cnt) +: SYM_W] = sym_data;
      wr_cnt = acc_cnt + CNT_W'(1);
    end

    // Draining behaves as a flush that stays asserted until the partial frame leaves
    flush_req = ((state == RUN) & flush) | end_accept | (state == DRAIN) | flush_pend;
    close     = (wr_cnt == CNT_W'(MAX_SYMS)) | (flush_req & (wr_cnt != '0));
    load      = close & out_free;

    load_frame.count  = wr_cnt;
    load_frame.buffer = wr_buf;

    if (load) begin
      acc_buf_n    = '0;
      acc_cnt_n    = '0;
      flush_pend_n = 1'b0;
    end else begin
      acc_buf_n = wr_buf;
      acc_cnt_n = wr_cnt;
      // Remember a blocked flush so the frame still closes once the output frees
      if (close & flush_req) begin
        flush_pend_n = 1'b1;
      end
    end

    unique case (state)
      RUN:     if (test_end_req) state_n = DRAIN;
      DRAIN:   if ((acc_cnt == '0) && !dct_valid) state_n = ENDED;
      ENDED:   state_n = ENDED;
      default: state_n = RUN;
    endcase

    // Registered sym_ready: predicts next cycle's RUN state and room in the accumulator
    sym_ready_n = (state_n == RUN) & (acc_cnt_n < CNT_W'(MAX_SYMS));
  end

  // State, accumulator and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      acc_buf        <= '0;
      acc_cnt        <= '0;
      flush_pend     <= 1'b0;
      sym_ready      <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_n;
      acc_buf        <= acc_buf_n;
      acc_cnt        <= acc_cnt_n;
      flush_pend     <= flush_pend_n;
      sym_ready      <= sym_ready_n;
      test_ending    <= end_accept;
      test_has_ended <= (state_n == ENDED);
    end
  end

  msoc_oci_frame_reg u_frame_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_frame (load_frame),
    .ready      (dct_ready),
    .valid      (dct_valid),
    .frame      (out_frame),
    .out_free_c (out_free)
  );

  assign dct_buffer = out_frame.buffer;
  assign dct_count  = out_frame.count;

endmodule
